// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: sequential instruction-fetch front end.
// Issues one fetch at a time over a valid/ready imem port, buffers the returned
// words in an FQ_DEPTH-entry queue and hands {instr, pc} to decode.
// Redirects flush the queue and squash the response of any fetch in flight.
// Optional build macro: FETCH_JUMP_PREDECODE_EN -- J/JAL words steer the next
// fetch address to the jump target as they are pushed.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4,
    localparam int unsigned CNT_W   = $clog2(FQ_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_rdy_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      instr_pc_o,
    input  logic             instr_ready_i,
    output logic [CNT_W-1:0] fq_count_o
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        outstanding_pc;
    logic               squash;

    logic [31:0]        fq_instr [FQ_DEPTH];
    logic [31:0]        fq_pc    [FQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               accept;
    logic               push;
    logic               pop;
    logic               still_outstanding;

`ifdef FETCH_JUMP_PREDECODE_EN
    logic               is_jump;
    logic [31:0]        jump_target;

    assign is_jump     = (imem_rdata_i[31:26] == 6'b000010) || (imem_rdata_i[31:26] == 6'b000011);
    assign jump_target = ((outstanding_pc + 32'd4) & 32'hF000_0000)
                       | {4'b0000, imem_rdata_i[25:0], 2'b00};
`endif

    // A request is only offered while a queue slot is free for its response.
    assign imem_req_o  = ~reset && (state == S_REQ) && (count < CNT_W'(FQ_DEPTH));
    assign imem_addr_o = fetch_pc;
    assign accept      = imem_req_o && imem_rdy_i;

    assign push = (state == S_WAIT) && imem_rvalid_i && !squash && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i;

    // After this cycle a fetch is still in flight if the current one has not
    // returned, or a new one is being accepted right now.
    assign still_outstanding = ((state == S_WAIT) && !imem_rvalid_i) || accept;

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? fq_instr[rd_ptr] : '0;
    assign instr_pc_o    = instr_valid_o ? fq_pc[rd_ptr]    : '0;
    assign fq_count_o    = count;

    // Fetch FSM, fetch address, squash flag and queue pointers/occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_REQ;
            fetch_pc       <= RESET_PC & 32'hFFFF_FFFC;
            outstanding_pc <= '0;
            squash         <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else if (redirect_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            if (still_outstanding) begin
                squash <= 1'b1;
                state  <= S_WAIT;
            end else begin
                squash <= 1'b0;
                state  <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        outstanding_pc <= fetch_pc;
                        fetch_pc       <= fetch_pc + 32'd4;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        squash <= 1'b0;
                        state  <= S_REQ;
`ifdef FETCH_JUMP_PREDECODE_EN
                        if (push && is_jump) begin
                            fetch_pc <= jump_target;
                        end
`endif
                    end
                end
                default: state <= S_REQ;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_instr[wr_ptr] <= imem_rdata_i;
            fq_pc[wr_ptr]    <= outstanding_pc;
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed testbench for mips_fetch_unit with a cycle-stepped imem model.
// Build with +define+FETCH_JUMP_PREDECODE_EN to expect jump predecode.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rdy_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic [2:0]  fq_count_o;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdy_i    (imem_rdy_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .fq_count_o    (fq_count_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // memory model state
    bit          pend;
    int unsigned pend_left;
    int unsigned lat;
    logic [31:0] pend_addr;
    logic [31:0] ovr [logic [31:0]];
    logic [31:0] acc_q [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_instr [$];
    bit          dead_seen;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return 32'hC000_0000 | a;
    endfunction

    function automatic logic [31:0] q_get(input logic [31:0] q [$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    // One clock cycle: called at a negedge with test inputs set, returns at the next negedge.
    task automatic tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (pend) begin
            pend_left--;
            if (pend_left == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(pend_addr);
                pend          = 1'b0;
            end
        end
        #1;
        if (instr_valid_o && instr_o == 32'hDEAD_BEEF) dead_seen = 1'b1;
        if (instr_valid_o && instr_ready_i) begin
            got_pc.push_back(instr_pc_o);
            got_instr.push_back(instr_o);
        end
        if (imem_req_o && imem_rdy_i) begin
            pend      = 1'b1;
            pend_left = lat;
            pend_addr = imem_addr_o;
            acc_q.push_back(imem_addr_o);
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        acc_q.delete();
        got_pc.delete();
        got_instr.delete();
        dead_seen = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        imem_rdy_i    = 1'b0;
        pend          = 1'b0;
        ovr.delete();
        clear_logs();
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        imem_rdy_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        pend          = 1'b0;
        lat           = 1;
        @(negedge clk);

        // reset state
        clear_logs();
        ticks(2);
        check_eq("rst_req",   {31'b0, imem_req_o},    32'd0);
        check_eq("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check_eq("rst_instr", instr_o,                32'd0);
        check_eq("rst_pc",    instr_pc_o,             32'd0);
        check_eq("rst_count", {29'b0, fq_count_o},    32'd0);
        reset = 1'b0;
        #1;
        check_eq("rel_req",  {31'b0, imem_req_o}, 32'd1);
        check_eq("rel_addr", imem_addr_o,         32'h0000_0000);

        // zero-wait memory, decode always ready: one pop every 2 cycles
        imem_rdy_i    = 1'b1;
        instr_ready_i = 1'b1;
        lat           = 1;
        ticks(20);
        check_eq("seq_npops",  got_pc.size(),       32'd9);
        check_eq("seq_pc0",    q_get(got_pc, 0),    32'h0000_0000);
        check_eq("seq_pc1",    q_get(got_pc, 1),    32'h0000_0004);
        check_eq("seq_pc2",    q_get(got_pc, 2),    32'h0000_0008);
        check_eq("seq_pc3",    q_get(got_pc, 3),    32'h0000_000C);
        check_eq("seq_instr0", q_get(got_instr, 0), 32'hC000_0000);
        check_eq("seq_instr3", q_get(got_instr, 3), 32'hC000_000C);

        // backpressure: queue fills to 4 and requests stop
        do_reset();
        imem_rdy_i = 1'b1;
        lat        = 1;
        ticks(20);
        check_eq("full_count", {29'b0, fq_count_o},    32'd4);
        check_eq("full_req",   {31'b0, imem_req_o},    32'd0);
        check_eq("full_nacc",  acc_q.size(),           32'd4);
        check_eq("full_valid", {31'b0, instr_valid_o}, 32'd1);
        check_eq("full_head",  instr_pc_o,             32'h0000_0000);
        check_eq("full_instr", instr_o,                32'hC000_0000);
        instr_ready_i = 1'b1;
        ticks(12);
        check_eq("resume_addr", q_get(acc_q, 4),  32'h0000_0010);
        check_eq("resume_pc3",  q_get(got_pc, 3), 32'h0000_000C);
        check_eq("resume_pc4",  q_get(got_pc, 4), 32'h0000_0010);

        // redirect while a 3-cycle fetch is outstanding
        do_reset();
        ovr[32'h0000_0000] = 32'hDEAD_BEEF;
        imem_rdy_i    = 1'b1;
        instr_ready_i = 1'b1;
        lat           = 3;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        check_eq("redir_count", {29'b0, fq_count_o}, 32'd0);
        check_eq("redir_req",   {31'b0, imem_req_o}, 32'd0);
        ticks(10);
        check_eq("redir_dead",   {31'b0, dead_seen},  32'd0);
        check_eq("redir_addr",   q_get(acc_q, 1),     32'h0000_0100);
        check_eq("redir_pc0",    q_get(got_pc, 0),    32'h0000_0100);
        check_eq("redir_instr0", q_get(got_instr, 0), 32'hC000_0100);

        // redirect, pop and rvalid in the same cycle
        do_reset();
        imem_rdy_i = 1'b1;
        lat        = 1;
        ticks(3);
        check_eq("sim_pre_count", {29'b0, fq_count_o}, 32'd1);
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        check_eq("sim_count", {29'b0, fq_count_o},    32'd0);
        check_eq("sim_valid", {31'b0, instr_valid_o}, 32'd0);
        check_eq("sim_req",   {31'b0, imem_req_o},    32'd1);
        check_eq("sim_addr",  imem_addr_o,            32'h0000_0200);
        got_pc.delete();
        got_instr.delete();
        ticks(4);
        check_eq("sim_pc0", q_get(got_pc, 0), 32'h0000_0200);

        // J word at 0x10
        do_reset();
        ovr[32'h0000_0010] = 32'h0800_0040;
        imem_rdy_i    = 1'b1;
        instr_ready_i = 1'b1;
        lat           = 1;
        ticks(16);
        check_eq("jmp_word_pc", q_get(got_pc, 4),    32'h0000_0010);
        check_eq("jmp_word",    q_get(got_instr, 4), 32'h0800_0040);
`ifdef FETCH_JUMP_PREDECODE_EN
        check_eq("jmp_next_addr", q_get(acc_q, 5), 32'h0000_0100);
`else
        check_eq("jmp_next_addr", q_get(acc_q, 5), 32'h0000_0014);
`endif

        // reset with a fetch outstanding, late rvalid after release
        do_reset();
        imem_rdy_i    = 1'b1;
        instr_ready_i = 1'b1;
        lat           = 3;
        tick();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        imem_rdy_i = 1'b0;
        tick();
        tick();
        check_eq("late_count", {29'b0, fq_count_o},    32'd0);
        check_eq("late_valid", {31'b0, instr_valid_o}, 32'd0);
        check_eq("late_nacc",  acc_q.size(),           32'd1);
        imem_rdy_i = 1'b1;
        lat        = 1;
        tick();
        check_eq("late_addr", q_get(acc_q, 1), 32'h0000_0000);
        ticks(3);
        check_eq("late_pc0",    q_get(got_pc, 0),    32'h0000_0000);
        check_eq("late_npops",  got_pc.size(),       32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
